// File: rtl/coin_validator_pkg.sv
// Shared coin codes and validator FSM states. The vending machine decodes
// the same COIN_* constants that the validator drives.
package coin_validator_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam int unsigned DCNT_W = 4;
  localparam int unsigned JCNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_EMIT         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/coin_validator_if.sv
// Sensor inputs and coin/audit outputs between the coin mechanism side
// (master) and the validator (slave).
interface coin_validator_if #(
  parameter int unsigned CNT_W = 8
);

  logic             sense_5;
  logic             sense_10;
  logic [1:0]       coin;
  logic             reject;
  logic             jam;
  logic [CNT_W-1:0] cnt_5;
  logic [CNT_W-1:0] cnt_10;

  modport master (
    output sense_5, sense_10,
    input  coin, reject, jam, cnt_5, cnt_10
  );

  modport slave (
    input  sense_5, sense_10,
    output coin, reject, jam, cnt_5, cnt_10
  );

endinterface

// File: rtl/coin_validator_sync2.sv
// Two-flop synchronizer for one raw asynchronous sensor line.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_validator.sv
// Coin validator: synchronizes and debounces two coin sensors, emits a
// one-cycle coin code, rejects double insertions and flags stuck sensors.
module coin_validator
  import coin_validator_pkg::*;
#(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned JAM_LIMIT = 255,
  parameter int unsigned CNT_W     = 8
) (
  input logic             clk,
  input logic             reset,
  coin_validator_if.slave bus
);

  localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEBOUNCE - 1);
  localparam logic [JCNT_W-1:0] JAM_LIM  = JCNT_W'(JAM_LIMIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic s5, s10;
  logic lat_s, other_s;

  state_t            state, next_state;
  logic [1:0]        ctype, ctype_next;
  logic [DCNT_W-1:0] dcnt, dcnt_next;
  logic [JCNT_W-1:0] jcnt, jcnt_next;
  logic [1:0]        coin_q, coin_next;
  logic              reject_q, reject_next;
  logic              jam_q, jam_next;
  logic [CNT_W-1:0]  cnt5_q, cnt5_next;
  logic [CNT_W-1:0]  cnt10_q, cnt10_next;

  sync2 u_sync_5  (.clk(clk), .reset(reset), .d(bus.sense_5),  .q(s5));
  sync2 u_sync_10 (.clk(clk), .reset(reset), .d(bus.sense_10), .q(s10));

  assign lat_s   = (ctype == COIN_5) ? s5  : s10;
  assign other_s = (ctype == COIN_5) ? s10 : s5;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // A rising second sensor outranks the latched one dropping: both cases
  // leave DEBOUNCE, but only the former is an invalid insertion.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (s5 && s10)      next_state = ST_WAIT_RELEASE;
        else if (s5 || s10) next_state = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (other_s)              next_state = ST_WAIT_RELEASE;
        else if (!lat_s)          next_state = ST_IDLE;
        else if (dcnt == DEB_LAST) next_state = ST_EMIT;
      end
      ST_EMIT: next_state = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: begin
        if (!jam_q && !s5 && !s10) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are computed one state early so coin/reject/jam leave flops.
  always_comb begin
    ctype_next  = ctype;
    dcnt_next   = dcnt;
    jcnt_next   = '0;
    coin_next   = COIN_NONE;
    reject_next = 1'b0;
    jam_next    = jam_q;
    cnt5_next   = cnt5_q;
    cnt10_next  = cnt10_q;
    case (state)
      ST_IDLE: begin
        dcnt_next   = '0;
        reject_next = s5 & s10;
        if (s5 ^ s10) ctype_next = s5 ? COIN_5 : COIN_10;
      end
      ST_DEBOUNCE: begin
        reject_next = other_s;
        if (next_state == ST_EMIT) begin
          coin_next = ctype;
          if (ctype == COIN_5) cnt5_next  = sat_inc(cnt5_q);
          else                 cnt10_next = sat_inc(cnt10_q);
        end else if (next_state == ST_DEBOUNCE) begin
          dcnt_next = dcnt + DCNT_W'(1);
        end
      end
      ST_WAIT_RELEASE: begin
        jcnt_next = jcnt;
        if (!jam_q && (s5 || s10)) begin
          jcnt_next = jcnt + JCNT_W'(1);
          if (jcnt_next == JAM_LIM) jam_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctype    <= COIN_NONE;
      dcnt     <= '0;
      jcnt     <= '0;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
      cnt5_q   <= '0;
      cnt10_q  <= '0;
    end else begin
      ctype    <= ctype_next;
      dcnt     <= dcnt_next;
      jcnt     <= jcnt_next;
      coin_q   <= coin_next;
      reject_q <= reject_next;
      jam_q    <= jam_next;
      cnt5_q   <= cnt5_next;
      cnt10_q  <= cnt10_next;
    end
  end

  assign bus.coin   = coin_q;
  assign bus.reject = reject_q;
  assign bus.jam    = jam_q;
  assign bus.cnt_5  = cnt5_q;
  assign bus.cnt_10 = cnt10_q;

endmodule

// File: doc/coin_validator.md
COIN_VALIDATOR -- requirements
Module: coin_validator

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4, cycles a sensor must stay stably high before a coin is accepted (legal range 1..15).
REQ-002 SHALL have parameter JAM_LIMIT, default 255, cycles a sensor may stay high after acceptance before a jam is declared (legal range 1..1023).
REQ-003 SHALL have parameter CNT_W, default 8, width of each audit counter.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sense_5  input  1  raw asynchronous 5/- coin sensor line; high means a coin is present.
REQ-007 sense_10  input  1  raw asynchronous 10/- coin sensor line; high means a coin is present.
REQ-008 coin  output  2  coin code for the downstream vending machine: 00 none, 01 5/-, 10 10/-; 11 is never driven.
REQ-009 reject  output  1  one-cycle pulse flagging an invalid insertion.
REQ-010 jam  output  1  sticky flag for a stuck sensor.
REQ-011 cnt_5  output  CNT_W  saturating count of accepted 5/- coins.
REQ-012 cnt_10  output  CNT_W  saturating count of accepted 10/- coins.

Function
REQ-013 Each sensor SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized values s5 and s10.
REQ-014 FSM states SHALL be IDLE, DEBOUNCE, EMIT and WAIT_RELEASE.
REQ-015 IDLE: exactly one of s5/s10 high -> DEBOUNCE; latch the coin type; clear the debounce counter.
REQ-016 IDLE: s5 and s10 both high -> pulse reject for 1 cycle, go to WAIT_RELEASE.
REQ-017 DEBOUNCE: latched sensor high, other low, counter < DEBOUNCE-1 -> increment the counter.
REQ-018 DEBOUNCE: latched sensor high, other low, counter == DEBOUNCE-1 -> EMIT.
REQ-019 DEBOUNCE: latched sensor drops -> IDLE with no coin and no reject (glitch is discarded).
REQ-020 DEBOUNCE: other sensor rises -> pulse reject for 1 cycle, go to WAIT_RELEASE; no coin is emitted.
REQ-021 EMIT: coin SHALL equal the latched code for exactly one cycle, the matching audit counter SHALL increment, then -> WAIT_RELEASE.
REQ-022 Latency: a clean sensor rise first sampled at edge 0 SHALL produce coin valid after edge 2+DEBOUNCE.
REQ-023 WAIT_RELEASE: both s5 and s10 low -> IDLE.
REQ-024 WAIT_RELEASE: otherwise the jam counter increments; on reaching JAM_LIMIT, jam SHALL set.
REQ-025 jam SHALL remain set until reset; while jam=1, coin SHALL stay 00 and the FSM SHALL stay in WAIT_RELEASE.
REQ-026 Audit counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-027 coin, reject and jam SHALL be driven directly from flops (registered outputs).
REQ-028 A coin SHALL never be emitted twice for one continuous sensor-high period.

Reset
REQ-029 Reset SHALL take effect immediately and asynchronously, independent of clk.
REQ-030 During reset, all outputs SHALL be 0 (coin=00, reject=0, jam=0, cnt_5=0, cnt_10=0).
REQ-031 During reset, state SHALL be IDLE, and both synchronizers and all counters SHALL be cleared.
REQ-032 A reset asserted mid-DEBOUNCE or mid-EMIT SHALL cancel any pending coin.
REQ-033 After reset deassertion, a sensor still held high SHALL be treated as a new insertion.

Structure
REQ-034 A shared package SHALL hold the coin code constants (COIN_NONE, COIN_5, COIN_10) and the FSM state encoding; the vending machine SHALL use the same coin code constants.
REQ-035 The block SHALL use one sub-module, sync2, a 2-flop synchronizer with asynchronous reset, instantiated once per sensor line.

Verification
REQ-036 Scenario: sense_5 high for 10 cycles, DEBOUNCE=4 -> coin=01 for exactly 1 cycle after edge 6; cnt_5=1; reject=0.
REQ-037 Scenario: sense_10 high for 2 cycles -> coin stays 00 and cnt_10 stays 0.
REQ-038 Scenario: sense_5 and sense_10 rising together -> one reject pulse; coin stays 00; both counters unchanged.
REQ-039 Scenario: sense_10 held high for 300 cycles, JAM_LIMIT=255 -> one coin=10 pulse, then jam=1 after about 255 more cycles; a later sense_5 pulse yields no coin.
REQ-040 Scenario: reset asserted 2 cycles into DEBOUNCE -> no coin output; all outputs are 0 immediately, before the next clk edge.
REQ-041 Scenario: 257 clean 5/- insertions with CNT_W=8 -> cnt_5 saturates at 255.
